dump_ctrl: RTL and testbench
============================

DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 384, sample RAM depth (12288 on DE-0).
REQ-002 SHALL have parameter LOG2, default 9, address/count width (must satisfy 2^LOG2 >= ENTRIES).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dump_start  input  1  single-cycle request from the command block to dump the captured buffer.
REQ-006 SHALL have port capture_done  input  1  capture-complete flag from the cmd_cfg register.
REQ-007 SHALL have port waddr  input  LOG2  capture write pointer; it addresses the oldest sample once capture is done.
REQ-008 SHALL have port ram_rdata  input  8  sample RAM read data, valid one clk after ren.
REQ-009 SHALL have port tx_done  input  1  single-cycle UART transmitter byte-complete pulse.
REQ-010 SHALL have port ren  output  1  RAM read enable.
REQ-011 SHALL have port raddr  output  LOG2  RAM read address.
REQ-012 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-013 SHALL have port trmt  output  1  single-cycle transmit strobe.
REQ-014 SHALL have port dump_busy  output  1  high while a dump is in progress.
REQ-015 SHALL have port dump_done  output  1  single-cycle completion pulse.
REQ-016 SHALL have port clr_capture_done  output  1  single-cycle request to clear capture_done in cmd_cfg.

Function
REQ-017 SHALL implement FSM states IDLE, READ, LATCH, XMIT, WAIT_TX, DONE.
REQ-018 IDLE: a dump_start with capture_done=1 SHALL load raddr<=waddr, clear sample count cnt (LOG2 bits), and go to READ.
REQ-019 IDLE: a dump_start with capture_done=0 SHALL be ignored; FSM stays in IDLE and no output pulses.
REQ-020 READ: ren SHALL be 1 for exactly this cycle; next state LATCH.
REQ-021 LATCH: tx_data SHALL register ram_rdata at the end of this cycle (one-cycle RAM latency); next state XMIT.
REQ-022 XMIT: trmt SHALL be 1 for exactly this cycle with tx_data stable; next state WAIT_TX.
REQ-023 WAIT_TX: the FSM SHALL hold until tx_done=1; tx_data SHALL stay stable while waiting.
REQ-024 On tx_done in WAIT_TX with cnt==ENTRIES-1, the FSM SHALL go to DONE; otherwise it SHALL increment cnt, advance raddr, and go to READ.
REQ-025 raddr SHALL advance modulo ENTRIES: ENTRIES-1 wraps to 0, never to 2^LOG2-1 or above.
REQ-026 DONE: dump_done and clr_capture_done SHALL both be 1 for exactly this cycle; next state IDLE.
REQ-027 Exactly ENTRIES bytes SHALL be sent per dump, in the order waddr, waddr+1, ... (mod ENTRIES).
REQ-028 dump_busy SHALL be 1 in every state except IDLE.
REQ-029 dump_start SHALL be ignored in all states other than IDLE.
REQ-030 tx_done SHALL be ignored in all states other than WAIT_TX.
REQ-031 waddr changes after dump_start is accepted SHALL NOT affect the dump in progress.
REQ-032 capture_done falling mid-dump SHALL NOT abort the dump.

Reset
REQ-033 While rst_n=0 the FSM SHALL be IDLE, raddr=0, cnt=0, tx_data=0x00, and ren, trmt, dump_busy, dump_done, clr_capture_done all 0.
REQ-034 Reset asserted mid-dump SHALL abort immediately, with no dump_done or clr_capture_done pulse.

Verification
REQ-035 ENTRIES=384, waddr=0, capture_done=1, RAM[i]=i[7:0], tx_done 10 cycles after each trmt, then dump_start -> 384 trmt pulses carrying 0x00..0xFF then 0x00..0x7F, followed by one dump_done/clr_capture_done pulse.
REQ-036 waddr=383 -> first raddr 383, second 0, last 382; 384 bytes total.
REQ-037 dump_start with capture_done=0 -> ren, trmt and dump_busy stay 0 for 20 cycles.
REQ-038 A second dump_start and stray tx_done pulses mid-dump -> byte count stays 384 and no extra trmt occurs.
REQ-039 Each ren -> tx_data equals the RAM word at raddr, and trmt fires exactly 2 cycles after ren.
REQ-040 rst_n low after byte 100 -> all outputs 0 immediately; a later dump_start restarts from waddr with a full 384 bytes.

Source files
------------

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams the captured sample buffer out through the UART, oldest sample first.
// Latency: READ->LATCH->XMIT per byte (trmt 2 clk after ren), then waits for tx_done.
// Backpressure: the UART paces the dump; the next RAM read is issued only after tx_done.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   dump_start          single-cycle dump request (honoured only in IDLE with capture_done=1)
//   capture_done        capture-complete flag
//   waddr               capture write pointer = oldest sample once capture is done
//   ram_rdata           sample RAM read data, valid one clk after ren
//   tx_done             UART byte-complete pulse
//   ren, raddr          sample RAM read port
//   tx_data, trmt       byte and transmit strobe to the UART
//   dump_busy           high in every state except IDLE
//   dump_done           single-cycle completion pulse
//   clr_capture_done    single-cycle request to clear capture_done
module dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic            capture_done,
  input  logic [LOG2-1:0] waddr,
  input  logic [7:0]      ram_rdata,
  input  logic            tx_done,
  output logic            ren,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            dump_busy,
  output logic            dump_done,
  output logic            clr_capture_done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    XMIT,
    WAIT_TX,
    DONE
  } state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  state_t          r_state;
  logic [LOG2-1:0] r_raddr;
  logic [LOG2-1:0] r_cnt;
  logic [7:0]      r_tx_data;
  logic            r_ren;
  logic            r_trmt;
  logic            r_busy;
  logic            r_done;
  logic            r_clr;

  logic            w_last_byte;
  logic [LOG2-1:0] w_raddr_nxt;

  assign w_last_byte = (r_cnt == LAST);
  // Address wraps at the buffer depth, not at 2^LOG2, so non-power-of-two depths stay in range.
  assign w_raddr_nxt = (r_raddr == LAST) ? '0 : r_raddr + LOG2'(1);

  // Outputs are registered: each pulse is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_raddr   <= '0;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
      r_ren     <= 1'b0;
      r_trmt    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clr     <= 1'b0;
    end else begin
      r_ren  <= 1'b0;
      r_trmt <= 1'b0;
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        IDLE: begin
          // waddr is sampled only here, so later pointer movement cannot disturb the dump.
          if (dump_start && capture_done) begin
            r_raddr <= waddr;
            r_cnt   <= '0;
            r_ren   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          r_state <= LATCH;
        end
        LATCH: begin
          // RAM data for the READ-cycle address is on ram_rdata now.
          r_tx_data <= ram_rdata;
          r_trmt    <= 1'b1;
          r_state   <= XMIT;
        end
        XMIT: begin
          r_state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            if (w_last_byte) begin
              r_done  <= 1'b1;
              r_clr   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt   <= r_cnt + LOG2'(1);
              r_raddr <= w_raddr_nxt;
              r_ren   <= 1'b1;
              r_state <= READ;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ren              = r_ren;
  assign raddr            = r_raddr;
  assign tx_data          = r_tx_data;
  assign trmt             = r_trmt;
  assign dump_busy        = r_busy;
  assign dump_done        = r_done;
  assign clr_capture_done = r_clr;

endmodule

// File: tb/tb_dump_ctrl.sv
// tb_dump_ctrl: scoreboard bench for dump_ctrl with a sample RAM model and a UART model.
// Expected RAM addresses and bytes are queued when a dump is requested; a monitor checks them.
// The UART model answers every trmt with tx_done 10 cycles later.
module tb_dump_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dump_start;
  logic            capture_done;
  logic [LOG2-1:0] waddr;
  logic [7:0]      ram_rdata;
  logic            tx_done;
  logic            ren;
  logic [LOG2-1:0] raddr;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            dump_busy;
  logic            dump_done;
  logic            clr_capture_done;

  logic            tx_model;
  logic            tx_stray;
  assign tx_done = tx_model | tx_stray;

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dump_start       (dump_start),
    .capture_done     (capture_done),
    .waddr            (waddr),
    .ram_rdata        (ram_rdata),
    .tx_done          (tx_done),
    .ren              (ren),
    .raddr            (raddr),
    .tx_data          (tx_data),
    .trmt             (trmt),
    .dump_busy        (dump_busy),
    .dump_done        (dump_done),
    .clr_capture_done (clr_capture_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ren_cyc = -100;
  int n_done = 0;
  int n_trmt_dump = 0;

  logic [7:0]      ram [ENTRIES];
  logic [LOG2-1:0] exp_addr[$];
  logic [7:0]      exp_byte[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {27'd0, ren, trmt, dump_busy, dump_done, clr_capture_done}, 32'd0);
    chk({name, "_raddr"}, 32'(raddr), 32'd0);
    chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  // Sample RAM: one-cycle read latency.
  always @(posedge clk) begin
    cyc++;
    if (ren) ram_rdata <= ram[raddr];
  end

  // UART transmitter model.
  initial begin
    tx_model = 1'b0;
    forever begin
      @(negedge clk);
      if (trmt) begin
        repeat (10) @(negedge clk);
        tx_model = 1'b1;
        @(negedge clk);
        tx_model = 1'b0;
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a read, a byte, or completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren) begin
        ren_cyc = cyc;
        if (exp_addr.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_ren: raddr 0x%0h, expected no read", raddr);
        end else begin
          chk("raddr", 32'(raddr), 32'(exp_addr.pop_front()));
        end
        chk("busy_on_ren", 32'(dump_busy), 32'd1);
      end
      if (trmt) begin
        n_trmt_dump++;
        chk("trmt_after_ren", 32'(cyc - ren_cyc), 32'd2);
        if (exp_byte.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_trmt: tx_data 0x%0h, expected no byte", tx_data);
        end else begin
          chk("tx_data", 32'(tx_data), 32'(exp_byte.pop_front()));
        end
      end
      if (dump_done) begin
        n_done++;
        chk("clr_with_done", 32'(clr_capture_done), 32'd1);
        chk("bytes_per_dump", 32'(n_trmt_dump), 32'(ENTRIES));
        chk("bytes_left", 32'(exp_byte.size()), 32'd0);
      end else if (clr_capture_done) begin
        n_chk++; n_err++;
        $display("FAIL clr_without_done: clr_capture_done 1, expected 0");
      end
    end
  end

  task automatic start_dump(input logic [LOG2-1:0] wa);
    @(negedge clk);
    waddr        = wa;
    capture_done = 1'b1;
    dump_start   = 1'b1;
    n_trmt_dump  = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      logic [LOG2-1:0] a;
      a = LOG2'((int'(wa) + i) % ENTRIES);
      exp_addr.push_back(a);
      exp_byte.push_back(ram[a]);
    end
    @(negedge clk);
    dump_start = 1'b0;
    chk("busy_after_start", 32'(dump_busy), 32'd1);
  endtask

  task automatic wait_done(input int target, input string name);
    int i;
    for (i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (n_done >= target) break;
    end
    if (n_done < target) begin
      n_err++;
      $display("FAIL %s_timeout: dump_done count %0d, expected %0d", name, n_done, target);
    end
    n_chk++;
    @(negedge clk);
    chk({name, "_idle_after"}, {30'd0, dump_busy, dump_done}, 32'd0);
  endtask

  task automatic wait_trmts(input int n);
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (n_trmt_dump >= n) break;
    end
  endtask

  task automatic wait_ren();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ren) break;
    end
  endtask

  initial begin
    int done_before;
    for (int i = 0; i < ENTRIES; i++) ram[i] = i[7:0];
    rst_n        = 1'b0;
    dump_start   = 1'b0;
    capture_done = 1'b0;
    waddr        = '0;
    tx_stray     = 1'b0;
    ram_rdata    = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Request without a completed capture is ignored.
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("no_capture_idle", {29'd0, ren, trmt, dump_busy}, 32'd0);
      @(negedge clk);
    end

    // Full dump from address 0; waddr moving mid-dump must not matter.
    start_dump(9'd0);
    waddr = 9'd77;
    wait_done(1, "dump_a0");

    // Dump from the last address (wraps to 0), with a stray request,
    // stray tx_done pulses and capture_done falling mid-dump.
    start_dump(9'd383);
    wait_trmts(5);
    wait_ren();
    tx_stray     = 1'b1;
    dump_start   = 1'b1;
    capture_done = 1'b0;
    @(negedge clk);
    tx_stray   = 1'b0;
    dump_start = 1'b0;
    @(negedge clk);
    tx_stray = 1'b1;   // XMIT cycle
    @(negedge clk);
    tx_stray = 1'b0;
    wait_done(2, "dump_a383");

    // Reset after byte 100 aborts with no completion pulse.
    start_dump(9'd10);
    wait_trmts(100);
    done_before = n_done;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_dump_reset");
    exp_addr.delete();
    exp_byte.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", 32'(n_done), 32'(done_before));
    chk("idle_after_abort", {29'd0, ren, trmt, dump_busy}, 32'd0);

    // Restart delivers a full dump from waddr.
    start_dump(9'd10);
    wait_done(done_before + 1, "dump_restart");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
